// File: rtl/bcd_to_bin_if.sv
// Handshake bundle for the sequential BCD-to-binary converter: BCD digits in, binary result out.
interface bcd_to_bin_if #(
    parameter int NDIGITS = 3,
    parameter int BIN_W   = 10
);
    logic                   in_valid;
    logic                   in_ready;
    logic [4*NDIGITS-1:0]   bcd_in;
    logic                   out_valid;
    logic                   out_ready;
    logic [BIN_W-1:0]       bin_out;
    logic                   err;

    modport master (
        output in_valid, bcd_in, out_ready,
        input  in_ready, out_valid, bin_out, err
    );

    modport slave (
        input  in_valid, bcd_in, out_ready,
        output in_ready, out_valid, bin_out, err
    );
endinterface

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter (reverse double dabble, one bit per clock).
// Optional feature macro DIGIT_CHECK_EN: reject digits > 9 with err=1 and a zero result.
module bcd_to_bin_seq #(
    parameter int NDIGITS = 3,
    parameter int BIN_W   = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    bcd_to_bin_if.slave     bus
);
    localparam int BCD_W = 4 * NDIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Every digit >= 8 loses 3; digits are independent, no borrow between them.
    function automatic logic [BCD_W-1:0] sub3_adjust(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        logic [3:0]       d;
        r = v;
        for (int i = 0; i < NDIGITS; i++) begin
            d = v[4*i +: 4];
            if (d >= 4'd8) begin
                r[4*i +: 4] = d - 4'd3;
            end else begin
                r[4*i +: 4] = d;
            end
        end
        return r;
    endfunction

`ifdef DIGIT_CHECK_EN
    function automatic logic digit_invalid(input logic [BCD_W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end else begin
                bad = bad;
            end
        end
        return bad;
    endfunction
`endif

    logic [1:0]        state_r,     state_s;
    logic [BCD_W-1:0]  bcd_r,       bcd_s;
    logic [BIN_W-1:0]  bin_r,       bin_s;
    logic [CNT_W-1:0]  cnt_r,       cnt_s;
    logic              bad_r,       bad_s;
    logic              out_valid_r, out_valid_s;
    logic              in_ready_r,  in_ready_s;
    logic [BIN_W-1:0]  bin_out_r,   bin_out_s;
    logic              err_r,       err_s;
    logic              accept_s;
    logic [BCD_W-1:0]  bcd_shift_s;

    assign accept_s    = bus.in_valid & in_ready_r;
    assign bcd_shift_s = {1'b0, bcd_r[BCD_W-1:1]};

    // Next-state and datapath update for the IDLE -> SHIFT -> DONE sequence.
    always_comb begin
        state_s     = state_r;
        bcd_s       = bcd_r;
        bin_s       = bin_r;
        cnt_s       = cnt_r;
        bad_s       = bad_r;
        out_valid_s = out_valid_r;
        bin_out_s   = bin_out_r;
        err_s       = err_r;
        case (state_r)
            ST_IDLE: begin
                out_valid_s = 1'b0;
                if (accept_s) begin
                    bcd_s   = bus.bcd_in;
                    bin_s   = '0;
                    cnt_s   = '0;
`ifdef DIGIT_CHECK_EN
                    bad_s   = digit_invalid(bus.bcd_in);
`else
                    bad_s   = 1'b0;
`endif
                    state_s = ST_SHIFT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                out_valid_s = 1'b0;
                if (bad_r) begin
                    // Rejected input: skip the shifting, report a zero result.
                    state_s = ST_DONE;
                end else begin
                    bin_s = {bcd_r[0], bin_r[BIN_W-1:1]};
                    bcd_s = sub3_adjust(bcd_shift_s);
                    cnt_s = cnt_r + CNT_W'(1);
                    if (cnt_r == LAST_CNT) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_SHIFT;
                    end
                end
            end
            ST_DONE: begin
                if (out_valid_r && bus.out_ready) begin
                    out_valid_s = 1'b0;
                    state_s     = ST_IDLE;
                end else if (!out_valid_r) begin
                    // First DONE cycle: capture the result into the output holding register.
                    out_valid_s = 1'b1;
                    bin_out_s   = bin_r;
                    err_s       = bad_r;
                end else begin
                    out_valid_s = 1'b1;
                end
            end
            default: begin
                state_s     = ST_IDLE;
                out_valid_s = 1'b0;
            end
        endcase
        in_ready_s = (state_s == ST_IDLE);
    end

    // State and output registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            bcd_r       <= '0;
            bin_r       <= '0;
            cnt_r       <= '0;
            bad_r       <= 1'b0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            bin_out_r   <= '0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            bcd_r       <= bcd_s;
            bin_r       <= bin_s;
            cnt_r       <= cnt_s;
            bad_r       <= bad_s;
            out_valid_r <= out_valid_s;
            in_ready_r  <= in_ready_s;
            bin_out_r   <= bin_out_s;
            err_r       <= err_s;
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.bin_out   = bin_out_r;
    assign bus.err       = err_r;
endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed bench for bcd_to_bin_seq: known vectors, full 000..999 sweep, backpressure, reset abort.
module tb_bcd_to_bin_seq;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    bcd_to_bin_if #(.NDIGITS(3), .BIN_W(10)) bus ();

    bcd_to_bin_seq #(.NDIGITS(3), .BIN_W(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for in_ready, accepts b, then counts edges until out_valid (bounded).
    task automatic convert(input logic [11:0] b, output int cyc, output bit rdy_busy);
        int n;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        bus.in_valid = 1'b1;
        bus.bcd_in   = b;
        step();
        bus.in_valid = 1'b0;
        bus.bcd_in   = 12'h000;
        cyc      = 0;
        rdy_busy = 1'b0;
        while (bus.out_valid !== 1'b1 && cyc < 40) begin
            if (bus.in_ready !== 1'b0) rdy_busy = 1'b1;
            step();
            cyc++;
        end
    endtask

    initial begin
        int          cyc;
        bit          rdy_busy;
        bit          seen;
        logic [11:0] b;
        logic [31:0] prev;
        tests = 0;
        fails = 0;
        bus.in_valid  = 1'b0;
        bus.bcd_in    = 12'h000;
        bus.out_ready = 1'b1;
        rst_n = 1'b0;
        step();
        step();
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_bin_out",   32'(bus.bin_out),   32'd0);
        chk("rst_err",       32'(bus.err),       32'd0);
        rst_n = 1'b1;
        step();

        convert(12'h999, cyc, rdy_busy);
        chk("999_latency", 32'(cyc), 32'd11);
        chk("999_bin",     32'(bus.bin_out), 32'h3E7);
        chk("999_err",     32'(bus.err), 32'd0);
        chk("999_busy_rdy", 32'(rdy_busy), 32'd0);
        prev = 32'(bus.bin_out);
        step();
        chk("999_consumed", 32'(bus.out_valid), 32'd0);
        chk("999_idle_rdy", 32'(bus.in_ready), 32'd1);
        chk("999_hold_last", 32'(bus.bin_out), prev);

        convert(12'h255, cyc, rdy_busy);
        chk("255_bin", 32'(bus.bin_out), 32'h0FF);
        convert(12'h000, cyc, rdy_busy);
        chk("000_bin", 32'(bus.bin_out), 32'h000);
        convert(12'h100, cyc, rdy_busy);
        chk("100_bin", 32'(bus.bin_out), 32'h064);

        // Invalid digit handling depends on the build option.
        convert(12'h1A3, cyc, rdy_busy);
`ifdef DIGIT_CHECK_EN
        chk("1a3_latency", 32'(cyc), 32'd2);
        chk("1a3_err",     32'(bus.err), 32'd1);
        chk("1a3_bin",     32'(bus.bin_out), 32'd0);
`else
        chk("1a3_latency", 32'(cyc), 32'd11);
        chk("1a3_err",     32'(bus.err), 32'd0);
`endif

        // Full sweep against the integer value of the digits.
        for (int i = 0; i < 1000; i++) begin
            b = {4'(i / 100), 4'((i / 10) % 10), 4'(i % 10)};
            convert(b, cyc, rdy_busy);
            chk($sformatf("sweep_%03d_bin", i), 32'(bus.bin_out), 32'(i));
            chk($sformatf("sweep_%03d_lat", i), 32'(cyc), 32'd11);
            chk($sformatf("sweep_%03d_rdy", i), 32'(rdy_busy), 32'd0);
            chk($sformatf("sweep_%03d_err", i), 32'(bus.err), 32'd0);
        end
        step();

        // Backpressure: result held for 20 cycles while a new request is offered.
        bus.out_ready = 1'b0;
        convert(12'h255, cyc, rdy_busy);
        chk("bp_latency", 32'(cyc), 32'd11);
        bus.in_valid = 1'b1;
        bus.bcd_in   = 12'h123;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.out_valid !== 1'b1 || bus.bin_out !== 10'h0FF || bus.in_ready !== 1'b0)
                seen = 1'b1;
        end
        chk("bp_held", 32'(seen), 32'd0);
        bus.in_valid  = 1'b0;
        bus.bcd_in    = 12'h000;
        bus.out_ready = 1'b1;
        step();
        chk("bp_released", 32'(bus.out_valid), 32'd0);
        chk("bp_bin_kept", 32'(bus.bin_out), 32'h0FF);
        convert(12'h100, cyc, rdy_busy);
        chk("bp_next_bin", 32'(bus.bin_out), 32'h064);
        step();

        // Reset five cycles into a conversion aborts it.
        bus.in_valid = 1'b1;
        bus.bcd_in   = 12'h999;
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        rst_n = 1'b0;
        #1;
        chk("abort_rdy_in_rst", 32'(bus.in_ready), 32'd1);
        step();
        step();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (bus.out_valid !== 1'b0) seen = 1'b1;
        end
        chk("abort_no_valid", 32'(seen), 32'd0);
        chk("abort_rdy",      32'(bus.in_ready), 32'd1);
        convert(12'h042, cyc, rdy_busy);
        chk("abort_next_bin", 32'(bus.bin_out), 32'h02A);
        chk("abort_next_lat", 32'(cyc), 32'd11);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
